// File: rtl/operand_sequencer_pkg.sv
// Shared defaults and FSM state encoding for the operand sequencer and its FIFO.
package operand_sequencer_pkg;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_FIFO_DEPTH  = 4;
  localparam int DEF_ADD_LATENCY = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/operand_fifo.sv
// Circular operand-pair buffer with registered occupancy; pushes are refused when full.
module operand_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic [LW-1:0]     level,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              full, do_push, do_pop;

  assign full    = level == LW'(DEPTH);
  assign empty   = level == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage needs no reset: an empty FIFO never exposes its contents.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/operand_sequencer.sv
// Buffers operand pairs and feeds them one at a time to a fixed-latency serial
// adder, holding each sum until the downstream consumer takes it.
module operand_sequencer
  import operand_sequencer_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int ADD_LATENCY = DEF_ADD_LATENCY
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_a_i,
  input  logic [WIDTH-1:0] in_b_i,
  output logic [WIDTH-1:0] add_a_o,
  output logic [WIDTH-1:0] add_b_o,
  output logic             add_start_o,
  input  logic [WIDTH:0]   add_sum_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH:0]   out_sum_o
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = $clog2(ADD_LATENCY) + 1;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [LW-1:0]      level;
  logic [2*WIDTH-1:0] head;
  logic               empty, push, pop, cnt_done;

  // Ready comes from registered occupancy only, so no input reaches it.
  assign in_ready_o  = level < LW'(FIFO_DEPTH);
  assign push        = in_valid_i && in_ready_o;
  assign pop         = (state == IDLE) && !empty;
  assign cnt_done    = cnt == CW'(ADD_LATENCY - 1);
  assign add_start_o = state == START;

  operand_fifo #(
    .DATA_W (2 * WIDTH),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (push),
    .pop    (pop),
    .wdata  ({in_a_i, in_b_i}),
    .rdata  (head),
    .level  (level),
    .empty  (empty)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!empty) state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT:    if (cnt_done) state_nxt = HOLD;
      HOLD:    if (out_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operands change only on an IDLE pop, so the adder sees them steady
  // from the start pulse until the result is consumed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      add_a_o     <= '0;
      add_b_o     <= '0;
      cnt         <= '0;
      out_valid_o <= 1'b0;
      out_sum_o   <= '0;
    end else begin
      if (pop) {add_a_o, add_b_o} <= head;
      if (state == START)     cnt <= '0;
      else if (state == WAIT) cnt <= cnt + 1'b1;
      if (state == WAIT && cnt_done) begin
        out_sum_o   <= add_sum_i;
        out_valid_o <= 1'b1;
      end else if (state == HOLD && out_ready_i) begin
        out_valid_o <= 1'b0;
      end
    end
  end

endmodule
